// File: rtl/uctl_bank_seq_if.sv
// Bank-sequencer bus: burst command/status, write/read word streams and one arbiter lane.
// The sequencer takes the slave view; the endpoint data path and memory side take the master view.
interface uctl_bank_seq_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 10
);
  logic                  seq_start;
  logic [ADDR_WIDTH-1:0] seq_startAddr;
  logic [LEN_WIDTH-1:0]  seq_len;
  logic                  seq_busy;
  logic                  seq_done;
  logic [DATA_WIDTH-1:0] seq_wrData;
  logic                  seq_wrValid;
  logic                  seq_wrReady;
  logic [DATA_WIDTH-1:0] seq_rdData;
  logic                  seq_rdValid;
  logic                  uctl_bankReq;
  logic                  uctl_ack;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wrData;
  logic [DATA_WIDTH-1:0] mem_rdData;

  modport slave (
    input  seq_start, seq_startAddr, seq_len, seq_wrData, seq_wrValid, uctl_ack, mem_rdData,
    output seq_busy, seq_done, seq_wrReady, seq_rdData, seq_rdValid, uctl_bankReq, mem_addr, mem_wrData
  );

  modport master (
    output seq_start, seq_startAddr, seq_len, seq_wrData, seq_wrValid, uctl_ack, mem_rdData,
    input  seq_busy, seq_done, seq_wrReady, seq_rdData, seq_rdValid, uctl_bankReq, mem_addr, mem_wrData
  );
endinterface

// File: rtl/uctl_bank_seq.sv
// Per-lane bank sequencer: expands a (start address, word count) burst into single-word arbiter requests.
// One word per granted cycle; read data is returned one cycle after its grant, write data is pulled through a one-word hold register.
module uctl_bank_seq #(
  parameter bit SEQ_WR     = 1'b1,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 10
) (
  input  logic           uctl_clk,
  input  logic           uctl_rst,
  uctl_bank_seq_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_XFER  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_rem;
  logic [LEN_WIDTH-1:0]  r_acc;
  logic [DATA_WIDTH-1:0] r_hold;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_hold_vld;
  logic                  r_rd_pend;
  logic                  r_req;
  logic                  r_busy;
  logic                  r_done;

  state_t w_state_nxt;
  logic   w_start;
  logic   w_beat;
  logic   w_last;
  logic   w_wr_rdy;
  logic   w_load;
  logic   w_hold_vld_nxt;

  always_comb begin
    w_start  = (r_state == S_IDLE) && bus.seq_start;
    w_beat   = r_req && bus.uctl_ack;
    w_last   = w_beat && (r_rem == LEN_WIDTH'(1));
    w_wr_rdy = SEQ_WR && (r_state == S_XFER) && (r_acc != '0) && (!r_hold_vld || bus.uctl_ack);
    w_load   = w_wr_rdy && bus.seq_wrValid;
    // a beat and a load in the same cycle leave the hold register full with the new word
    w_hold_vld_nxt = w_load ? 1'b1 : (w_beat ? 1'b0 : r_hold_vld);

    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = (bus.seq_len == '0) ? S_DONE : S_XFER;
      S_XFER:  if (w_last)  w_state_nxt = SEQ_WR ? S_DONE : S_DRAIN;
      S_DRAIN: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge uctl_clk or posedge uctl_rst) begin
    if (uctl_rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_rem      <= '0;
      r_acc      <= '0;
      r_hold     <= '0;
      r_rd_data  <= '0;
      r_hold_vld <= 1'b0;
      r_rd_pend  <= 1'b0;
      r_req      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
      r_done     <= (w_state_nxt == S_DONE);
      r_req      <= (w_state_nxt == S_XFER) && (!SEQ_WR || w_hold_vld_nxt);
      r_hold_vld <= w_hold_vld_nxt;
      r_rd_pend  <= w_beat && !SEQ_WR;

      if (w_start) begin
        r_addr <= bus.seq_startAddr;
        r_rem  <= bus.seq_len;
        r_acc  <= SEQ_WR ? bus.seq_len : '0;
      end else if (w_beat) begin
        r_addr <= r_addr + ADDR_WIDTH'(1);
        r_rem  <= r_rem - LEN_WIDTH'(1);
      end

      // the accept count caps intake at the burst length
      if (w_load) begin
        r_acc  <= r_acc - LEN_WIDTH'(1);
        r_hold <= bus.seq_wrData;
      end

      if (r_rd_pend) begin
        r_rd_data <= bus.mem_rdData;
      end
    end
  end

  assign bus.seq_busy     = r_busy;
  assign bus.seq_done     = r_done;
  assign bus.uctl_bankReq = r_req;
  assign bus.mem_addr     = r_addr;
  assign bus.seq_wrReady  = w_wr_rdy;
  assign bus.mem_wrData   = SEQ_WR ? r_hold : '0;
  assign bus.seq_rdValid  = SEQ_WR ? 1'b0 : r_rd_pend;
  // memory data is forwarded in its strobe cycle and held afterwards
  assign bus.seq_rdData   = SEQ_WR ? '0 : (r_rd_pend ? bus.mem_rdData : r_rd_data);

endmodule

// File: tb/tb_uctl_bank_seq.sv
// Bench for uctl_bank_seq: one write-lane and one read-lane instance driven from a burst table,
// with queued expected words checked as the lanes emit them, plus a mid-burst reset sequence.
module tb_uctl_bank_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  uctl_bank_seq_if if_wr ();
  uctl_bank_seq_if if_rd ();

  uctl_bank_seq #(.SEQ_WR(1'b1)) u_wr (.uctl_clk(clk), .uctl_rst(rst), .bus(if_wr));
  uctl_bank_seq #(.SEQ_WR(1'b0)) u_rd (.uctl_clk(clk), .uctl_rst(rst), .bus(if_rd));

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [9:0]  len;
    int          stall;
    bit          poke;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] wword(input logic [15:0] a, input int i);
    return {a ^ 16'h5A5A, 16'(i)};
  endfunction

  function automatic logic [31:0] rword(input logic [15:0] a);
    return {~a, a};
  endfunction

  task automatic drive(input bit wr, input logic st, input logic [15:0] a, input logic [9:0] l,
                       input logic ack, input logic wv, input logic [31:0] wd, input logic [31:0] rd);
    if_wr.seq_start     = wr ? st : 1'b0;
    if_wr.seq_startAddr = a;
    if_wr.seq_len       = l;
    if_wr.uctl_ack      = wr ? ack : 1'b0;
    if_wr.seq_wrValid   = wr ? wv : 1'b0;
    if_wr.seq_wrData    = wd;
    if_wr.mem_rdData    = rd;
    if_rd.seq_start     = wr ? 1'b0 : st;
    if_rd.seq_startAddr = a;
    if_rd.seq_len       = l;
    if_rd.uctl_ack      = wr ? 1'b0 : ack;
    if_rd.seq_wrValid   = wr ? 1'b0 : wv;
    if_rd.seq_wrData    = wd;
    if_rd.mem_rdData    = rd;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wr_ctl"}, 64'({if_wr.seq_busy, if_wr.seq_done, if_wr.seq_wrReady, if_wr.seq_rdValid,
                               if_wr.uctl_bankReq, if_wr.mem_addr}), 64'd0);
    chk({tag, "_wr_dat"}, 64'({if_wr.mem_wrData, if_wr.seq_rdData}), 64'd0);
    chk({tag, "_rd_ctl"}, 64'({if_rd.seq_busy, if_rd.seq_done, if_rd.seq_wrReady, if_rd.seq_rdValid,
                               if_rd.uctl_bankReq, if_rd.mem_addr}), 64'd0);
    chk({tag, "_rd_dat"}, 64'({if_rd.mem_wrData, if_rd.seq_rdData}), 64'd0);
  endtask

  task automatic run_burst(input vec_t v);
    logic [15:0] exp_addr;
    logic [15:0] pend_addr;
    logic [31:0] wq[$];
    logic [31:0] rq[$];
    logic [31:0] mrd;
    logic [31:0] exp_w;
    logic        pend;
    logic        s_req, s_ack, s_rdy, s_rvld, s_done, s_busy;
    logic [15:0] s_addr;
    logic [31:0] s_wdat, s_rdat;
    int          beats, nacc, nrd;

    exp_addr  = v.addr;
    pend_addr = '0;
    pend      = 1'b0;
    beats     = 0;
    nacc      = 0;
    nrd       = 0;

    @(negedge clk);
    drive(v.wr, 1'b1, v.addr, v.len, 1'b0, 1'b0, '0, '0);

    for (int c = 1; c <= v.lat + 2; c++) begin
      @(negedge clk);
      mrd = 32'hDEAD_BEEF;
      if (pend) begin
        mrd = rword(pend_addr);
        rq.push_back(mrd);
      end
      pend = 1'b0;
      // an optional stray start with a different command while the burst is live
      drive(v.wr, v.poke && (c == 1), 16'hAAAA, 10'd7, c > v.stall, 1'b1, wword(v.addr, nacc), mrd);
      #1;
      s_req  = v.wr ? if_wr.uctl_bankReq : if_rd.uctl_bankReq;
      s_ack  = v.wr ? if_wr.uctl_ack     : if_rd.uctl_ack;
      s_rdy  = v.wr ? if_wr.seq_wrReady  : if_rd.seq_wrReady;
      s_rvld = v.wr ? if_wr.seq_rdValid  : if_rd.seq_rdValid;
      s_done = v.wr ? if_wr.seq_done     : if_rd.seq_done;
      s_busy = v.wr ? if_wr.seq_busy     : if_rd.seq_busy;
      s_addr = v.wr ? if_wr.mem_addr     : if_rd.mem_addr;
      s_wdat = v.wr ? if_wr.mem_wrData   : if_rd.mem_wrData;
      s_rdat = v.wr ? if_wr.seq_rdData   : if_rd.seq_rdData;

      if (s_req) chk("mem_addr", 64'(s_addr), 64'(exp_addr));
      if (s_req && s_ack) begin
        beats++;
        if (v.wr) begin
          chk("wr_word_available", 64'(wq.size() > 0), 64'd1);
          if (wq.size() > 0) begin
            exp_w = wq.pop_front();
            chk("mem_wrData", 64'(s_wdat), 64'(exp_w));
          end
        end else begin
          pend      = 1'b1;
          pend_addr = exp_addr;
        end
        exp_addr++;
      end
      if (s_rdy) begin
        chk("accept_within_len", 64'(nacc < int'(v.len)), 64'd1);
        wq.push_back(wword(v.addr, nacc));
        nacc++;
      end
      if (s_rvld) begin
        nrd++;
        chk("rd_word_available", 64'(rq.size() > 0), 64'd1);
        if (rq.size() > 0) begin
          exp_w = rq.pop_front();
          chk("seq_rdData", 64'(s_rdat), 64'(exp_w));
        end
      end
      chk("seq_done", 64'(s_done), 64'(c == v.lat));
      chk("seq_busy", 64'(s_busy), 64'(c <= v.lat));
    end

    drive(v.wr, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    chk("beat_count", 64'(beats), 64'(v.len));
    chk("accept_count", 64'(nacc), v.wr ? 64'(v.len) : 64'd0);
    chk("rdvalid_count", 64'(nrd), v.wr ? 64'd0 : 64'(v.len));
    chk("queues_drained", 64'(wq.size() + rq.size()), 64'd0);
  endtask

  initial begin
    int   beats;
    vec_t tail;

    // wr, addr, len, stall cycles, stray start, expected seq_done offset from start cycle
    vecs[0] = '{1'b0, 16'h0010, 10'd4, 0, 1'b0, 6};
    vecs[1] = '{1'b1, 16'hFFFE, 10'd3, 0, 1'b1, 5};
    vecs[2] = '{1'b0, 16'h1234, 10'd2, 5, 1'b0, 9};
    vecs[3] = '{1'b1, 16'h0100, 10'd0, 0, 1'b1, 1};
    vecs[4] = '{1'b0, 16'h0000, 10'd0, 0, 1'b1, 1};
    vecs[5] = '{1'b1, 16'h0200, 10'd5, 2, 1'b0, 8};
    vecs[6] = '{1'b0, 16'hFFFF, 10'd3, 0, 1'b1, 5};
    vecs[7] = '{1'b1, 16'h0040, 10'd1, 0, 1'b0, 3};

    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    #1;
    chk_reset_outputs("por");
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_burst(vecs[i]);
    end

    // abandon a len 8 write after its second beat
    @(negedge clk);
    drive(1'b1, 1'b1, 16'h0300, 10'd8, 1'b1, 1'b1, wword(16'h0300, 0), '0);
    beats = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 16'h0300, 10'd8, 1'b1, 1'b1, wword(16'h0300, c), '0);
      #1;
      if (if_wr.uctl_bankReq && if_wr.uctl_ack) beats++;
    end
    chk("midrst_beats_before", 64'(beats), 64'd2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("midrst_no_done", 64'(if_wr.seq_done), 64'd0);
      chk("midrst_idle", 64'(if_wr.seq_busy), 64'd0);
    end
    tail = '{1'b1, 16'h0400, 10'd1, 0, 1'b0, 3};
    run_burst(tail);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not reach its summary line");
    $fatal(1, "watchdog expired");
  end

endmodule
